branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL be parameterised as follows:
- XLEN, default 32: PC and target width.
- ENTRIES, default 64: table depth; power of 2, at least 2; IDX_W = log2(ENTRIES).
- STAT_W, default 32: width of the statistics counters.

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- lookup_pc, input, XLEN: fetch-stage PC.
- pred_taken, output, 1: prediction for lookup_pc; combinational.
- pred_target, output, XLEN: predicted next PC for lookup_pc; combinational.
- upd_valid, input, 1: a conditional branch resolved in decode this cycle.
- upd_pc, input, XLEN: PC of the resolved branch.
- upd_taken, input, 1: actual branch outcome.
- upd_target, input, XLEN: actual branch target.
- upd_pred_taken, input, 1: pred_taken value that fetch used for this branch.
- upd_pred_target, input, XLEN: pred_target value that fetch used for this branch.
- mispredict, output, 1: redirect request; combinational.
- clear_stats, input, 1: synchronous clear of the statistics counters.
- stat_branches, output, STAT_W: resolved-branch count; registered.
- stat_mispredicts, output, STAT_W: mispredict count; registered.

Function
REQ-003 The block SHALL split any PC into index = pc[IDX_W+1:2] and tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
REQ-004 Each table entry SHALL hold: valid (1 bit), tag, target (XLEN bits) and a 2-bit saturating counter ctr.
REQ-005 A lookup SHALL be a hit when the indexed entry is valid and its tag equals the tag of lookup_pc.
REQ-006 pred_taken SHALL equal hit AND ctr[1].
REQ-007 pred_target SHALL be the entry target when pred_taken=1, otherwise lookup_pc+4 (modulo 2^XLEN).
REQ-008 mispredict SHALL equal upd_valid AND (upd_taken != upd_pred_taken OR (upd_taken AND upd_pred_target != upd_target)).
REQ-009 When upd_valid=1 and the entry indexed by upd_pc hits, the rising edge SHALL update it as follows:
- ctr increments on taken and decrements on not-taken, saturating at 2'b11 and 2'b00.
- target is written with upd_target when upd_taken=1.
REQ-010 When upd_valid=1, the entry misses and upd_taken=1, the rising edge SHALL allocate it: valid=1, tag=upd_pc tag, target=upd_target, ctr=2'b10.
REQ-011 When upd_valid=1, the entry misses and upd_taken=0, the table SHALL NOT change.
REQ-012 Allocation into a valid entry with a different tag SHALL replace it; there is no associativity.
REQ-013 When lookup and update address the same index in the same cycle, the lookup SHALL see the pre-edge contents; there is no bypass.
REQ-014 The table SHALL have exactly one write port and SHALL be updated at most once per cycle.
REQ-015 Each edge with upd_valid=1 SHALL increment stat_branches; each edge with mispredict=1 SHALL increment stat_mispredicts. Both SHALL saturate at all-ones.
REQ-016 clear_stats=1 SHALL zero both statistics counters at the next edge, overriding any same-cycle increment; table contents are unaffected.
REQ-017 The table SHALL NOT change when upd_valid=0, whatever the values on the other upd_* inputs.

Reset
REQ-018 Asserting rst SHALL immediately, without waiting for a clock edge, clear every valid bit, set every ctr to 2'b01, and zero stat_branches and stat_mispredicts.
REQ-019 While rst=1, the outputs SHALL be pred_taken=0 and pred_target=lookup_pc+4; mispredict continues to follow REQ-008.
REQ-020 Assertion of rst in the middle of operation SHALL discard any same-cycle update.
REQ-021 The first edge after rst deasserts SHALL behave as a normal cycle.

Verification
All scenarios use ENTRIES=64.
REQ-022 Cold reset: after reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, both stats = 0.
REQ-023 Allocate on taken miss:
- Stimulus: update pc=0x100, taken=1, target=0x80, pred_taken=0.
- Same cycle: mispredict=1.
- After the edge: lookup 0x100 -> pred_taken=1, pred_target=0x80; stat_branches=1, stat_mispredicts=1.
REQ-024 Counter hysteresis on pc=0x100, starting from ctr=10:
- taken, taken -> ctr=11 (saturated).
- not-taken -> ctr=10; pred_taken stays 1.
- not-taken -> ctr=01; pred_taken=0.
- four more not-taken -> ctr stays 00.
REQ-025 Aliasing: 0x100 allocated; lookup 0x200 (same index 0, different tag) -> pred_taken=0. Then a taken update of 0x200 with target 0x300 -> lookup 0x200 hits with pred_target=0x300, and lookup 0x100 now misses.
REQ-026 Same-cycle conflict: lookup 0x100 while a not-taken update of 0x100 at ctr=10 is presented -> pred_taken=1 in that cycle and 0 after the edge.
REQ-027 Asynchronous reset mid-run: with entries valid and stats nonzero, pulse rst between clock edges -> pred_taken=0 and both stats = 0 before the next edge, and a same-cycle upd_valid has no effect.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// and saturating resolved-branch / mispredict statistics.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   lookup_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              mispredict,
    input  logic              clear_stats,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Update interface: upd_valid qualifies all upd_* inputs for exactly one
    // cycle; there is no ready, the predictor always accepts the update.

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [XLEN-1:0]  tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    logic             wr_en;
    logic [XLEN-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup reads the pre-edge table; no bypass from a same-cycle update.
    assign lk_hit      = !rst && tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
    assign up_hit      = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
    assign pred_taken  = lk_hit && tbl_ctr[lk_idx][1];
    assign pred_target = pred_taken ? tbl_target[lk_idx] : lookup_pc + XLEN'(4);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_comb begin
        wr_en     = 1'b0;
        wr_target = tbl_target[up_idx];
        wr_ctr    = tbl_ctr[up_idx];
        if (upd_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_target = upd_target;
                    wr_ctr    = (tbl_ctr[up_idx] == 2'b11) ? 2'b11 : tbl_ctr[up_idx] + 2'd1;
                end else begin
                    wr_ctr    = (tbl_ctr[up_idx] == 2'b00) ? 2'b00 : tbl_ctr[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate (or replace an aliasing entry) weakly taken.
                wr_en     = 1'b1;
                wr_target = upd_target;
                wr_ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            tbl_valid[up_idx]  <= 1'b1;
            tbl_tag[up_idx]    <= up_tag;
            tbl_target[up_idx] <= wr_target;
            tbl_ctr[up_idx]    <= wr_ctr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (clear_stats) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && (stat_branches != '1))
                stat_branches <= stat_branches + STAT_W'(1);
            if (mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against an arithmetic reference model of the predictor.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int STAT_W  = 4;
    localparam int STAT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [XLEN-1:0]   lookup_pc = '0;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              upd_valid = 1'b0;
    logic [XLEN-1:0]   upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic [XLEN-1:0]   upd_target = '0;
    logic              upd_pred_taken = 1'b0;
    logic [XLEN-1:0]   upd_pred_target = '0;
    logic              mispredict;
    logic              clear_stats = 1'b0;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: entry keyed by (pc/4) mod ENTRIES, identified by pc/256.
    bit        m_valid [ENTRIES];
    int        m_line  [ENTRIES];
    bit [31:0] m_target[ENTRIES];
    int        m_ctr   [ENTRIES];
    int        m_br;
    int        m_mp;
    logic [STAT_W-1:0] exp_q[$];

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .clear_stats(clear_stats),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input bit [31:0] pc);
        return m_valid[idx_of(pc)] && (m_line[idx_of(pc)] == int'(pc / 256));
    endfunction

    function automatic bit m_pred_taken(input bit [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic bit [31:0] m_pred_target(input bit [31:0] pc);
        return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_line[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_edge();
        int i;
        if (clear_stats) begin
            m_br = 0;
            m_mp = 0;
        end else begin
            if (upd_valid && m_br < STAT_MAX) m_br++;
            if (m_mispredict() && m_mp < STAT_MAX) m_mp++;
        end
        if (upd_valid) begin
            i = idx_of(upd_pc);
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1; m_line[i] = int'(upd_pc / 256);
                m_target[i] = upd_target; m_ctr[i] = 2;
            end
        end
    endtask

    task automatic drive_upd(input bit [31:0] pc, input bit tk, input bit [31:0] tgt,
                             input bit ptk, input bit [31:0] ptgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    // Advance one clock: model consumes the pre-edge inputs, then the DUT edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        lookup_pc = 32'h100;
        #3;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred_taken_during: got %0b want 0", pred_taken); end
        n_cmp++;
        if (pred_target !== 32'h104) begin n_fail++; $display("FAIL rst_pred_target_during: got %h want 104", pred_target); end
        n_cmp++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
        n_cmp++;
        if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h want 104", pred_target); end
        n_cmp++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
        n_cmp++;
    endtask

    task automatic test_allocate();
        drive_upd(32'h100, 1, 32'h80, 0, 32'h104);
        lookup_pc = 32'h100;
        #1;
        if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict: got %0b want 1", mispredict); end
        n_cmp++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alloc_pre_edge: got %0b want 0", pred_taken); end
        n_cmp++;
        tick();
        #1;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++; $display("FAIL alloc_lookup: got %0b/%h want 1/00000080", pred_taken, pred_target);
        end
        n_cmp++;
        if (stat_branches !== 1 || stat_mispredicts !== 1) begin
            n_fail++; $display("FAIL alloc_stats: got %0d/%0d want 1/1", stat_branches, stat_mispredicts);
        end
        n_cmp++;
    endtask

    task automatic test_hysteresis();
        // Outcome sequence from ctr=10 and the direction expected after each edge.
        bit seq_tk [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        bit seq_exp[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        lookup_pc = 32'h100;
        for (int k = 0; k < 10; k++) begin
            drive_upd(32'h100, seq_tk[k], 32'h80, pred_taken, pred_target);
            tick();
            #1;
            if (pred_taken !== seq_exp[k]) begin
                n_fail++; $display("FAIL hysteresis_step%0d: got %0b want %0b", k, pred_taken, seq_exp[k]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_conflict();
        lookup_pc = 32'h100;
        drive_upd(32'h100, 0, 32'h0, 1, 32'h80);
        #1;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL conflict_same_cycle: got %0b want 1", pred_taken); end
        n_cmp++;
        if (mispredict !== 1'b1) begin n_fail++; $display("FAIL conflict_mispredict: got %0b want 1", mispredict); end
        n_cmp++;
        tick();
        #1;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL conflict_after_edge: got %0b want 0", pred_taken); end
        n_cmp++;
    endtask

    task automatic test_alias();
        drive_upd(32'h100, 1, 32'h80, 0, 32'h104);
        tick();
        lookup_pc = 32'h200;
        #1;
        if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
            n_fail++; $display("FAIL alias_miss: got %0b/%h want 0/00000204", pred_taken, pred_target);
        end
        n_cmp++;
        drive_upd(32'h200, 1, 32'h300, 0, 32'h204);
        tick();
        #1;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            n_fail++; $display("FAIL alias_replace: got %0b/%h want 1/00000300", pred_taken, pred_target);
        end
        n_cmp++;
        lookup_pc = 32'h100;
        #1;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL alias_evicted: got %0b/%h want 0/00000104", pred_taken, pred_target);
        end
        n_cmp++;
    endtask

    task automatic test_stat_saturation();
        clear_stats = 1'b1;
        tick();
        // Not-taken branches predicted taken: mispredicts that never allocate.
        for (int k = 0; k < STAT_MAX + 3; k++) begin
            drive_upd(32'h3F0, 0, 32'h0, 1, 32'h40);
            tick();
        end
        #1;
        if (stat_branches !== 4'd15 || stat_mispredicts !== 4'd15) begin
            n_fail++; $display("FAIL stat_saturate: got %0d/%0d want 15/15", stat_branches, stat_mispredicts);
        end
        n_cmp++;
        drive_upd(32'h3F0, 1, 32'h44, 0, 32'h3F4);
        clear_stats = 1'b1;
        tick();
        #1;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            n_fail++; $display("FAIL stat_clear_override: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
        n_cmp++;
        lookup_pc = 32'h200;
        #1;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            n_fail++; $display("FAIL clear_keeps_table: got %0b/%h want 1/00000300", pred_taken, pred_target);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        bit [31:0] pc;
        for (int c = 0; c < 400; c++) begin
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            lookup_pc = pc;
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            upd_valid       = ($urandom_range(0, 3) != 0);
            upd_pc          = pc;
            upd_taken       = $urandom_range(0, 1);
            upd_target      = $urandom_range(0, 15) << 4;
            upd_pred_taken  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : m_pred_taken(pc);
            upd_pred_target = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) << 4 : m_pred_target(pc);
            clear_stats     = ($urandom_range(0, 24) == 0);
            #1;
            if (pred_taken !== m_pred_taken(lookup_pc) || pred_target !== m_pred_target(lookup_pc)) begin
                n_fail++;
                $display("FAIL rand_lookup c%0d pc %h: got %0b/%h want %0b/%h", c, lookup_pc,
                         pred_taken, pred_target, m_pred_taken(lookup_pc), m_pred_target(lookup_pc));
            end
            n_cmp++;
            if (mispredict !== m_mispredict()) begin
                n_fail++; $display("FAIL rand_mispredict c%0d: got %0b want %0b", c, mispredict, m_mispredict());
            end
            n_cmp++;
            tick();
            exp_q.push_back(STAT_W'(m_br));
            exp_q.push_back(STAT_W'(m_mp));
            if (stat_branches !== exp_q.pop_front()) begin
                n_fail++; $display("FAIL rand_stat_branches c%0d: got %0d want %0d", c, stat_branches, m_br);
            end
            n_cmp++;
            if (stat_mispredicts !== exp_q.pop_front()) begin
                n_fail++; $display("FAIL rand_stat_mispredicts c%0d: got %0d want %0d", c, stat_mispredicts, m_mp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_async_reset();
        drive_upd(32'h100, 1, 32'h80, 0, 32'h104);
        tick();
        drive_upd(32'h140, 1, 32'h500, 0, 32'h144);
        lookup_pc = 32'h100;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL async_rst_pred: got %0b/%h want 0/00000104", pred_taken, pred_target);
        end
        n_cmp++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            n_fail++; $display("FAIL async_rst_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
        n_cmp++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        upd_valid = 1'b0;
        lookup_pc = 32'h140;
        #1;
        if (pred_taken !== 1'b0 || stat_branches !== 0) begin
            n_fail++; $display("FAIL async_rst_drop_update: got %0b/%0d want 0/0", pred_taken, stat_branches);
        end
        n_cmp++;
        drive_upd(32'h140, 1, 32'h500, 0, 32'h144);
        tick();
        #1;
        if (pred_taken !== 1'b1 || pred_target !== 32'h500 || stat_branches !== 1) begin
            n_fail++; $display("FAIL post_rst_first_edge: got %0b/%h/%0d want 1/00000500/1",
                               pred_taken, pred_target, stat_branches);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_conflict();
        test_alias();
        test_stat_saturation();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
